// File: rtl/mips16_pkg.sv
// mips16_pkg: shared opcode, funct, ALU-op and control-bit definitions for the 16-bit MIPS pipeline
package mips16_pkg;
    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b1011;
    localparam logic [3:0] OP_SW   = 4'b1111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b0010;

    localparam logic [2:0] F_SLT   = 3'b100;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    localparam int CTRL_W       = 7;
    localparam int C_ALU_SRC    = 6;
    localparam int C_MEM_READ   = 5;
    localparam int C_MEM_WRITE  = 4;
    localparam int C_REG_WRITE  = 3;
    localparam int C_MEM_TO_REG = 2;
    localparam int C_BRANCH     = 1;
    localparam int C_JUMP       = 0;
endpackage

// File: rtl/mips16_decoder.sv
// mips16_decoder: combinational instruction decode into ALU op, control bits, register fields and immediate
module mips16_decoder
    import mips16_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_instr,
    output alu_op_e           o_alu_op,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [2:0]        o_wreg,
    output logic [2:0]        o_rs,
    output logic [2:0]        o_rt,
    output logic              o_uses_rt,
    output logic [DATA_W-1:0] o_imm
);
    logic [3:0] w_op;
    logic [2:0] w_funct;

    assign w_op    = i_instr[15:12];
    assign w_funct = i_instr[2:0];
    assign o_rs    = i_instr[11:9];
    assign o_rt    = i_instr[8:6];
    assign o_imm   = {{(DATA_W-6){i_instr[5]}}, i_instr[5:0]};

    // Unknown opcodes and R-type functs fall through as NOPs with all control bits clear
    always_comb begin
        o_alu_op  = ALU_ADD;
        o_ctrl    = '0;
        o_wreg    = '0;
        o_uses_rt = 1'b0;
        case (w_op)
            OP_R: begin
                o_uses_rt = 1'b1;
                if (w_funct <= F_SLT) begin
                    o_alu_op              = alu_op_e'(w_funct);
                    o_ctrl[C_REG_WRITE]   = 1'b1;
                    o_wreg                = i_instr[5:3];
                end
            end
            OP_ADDI: begin
                o_ctrl[C_ALU_SRC]   = 1'b1;
                o_ctrl[C_REG_WRITE] = 1'b1;
                o_wreg              = i_instr[8:6];
            end
            OP_LW: begin
                o_ctrl[C_ALU_SRC]    = 1'b1;
                o_ctrl[C_MEM_READ]   = 1'b1;
                o_ctrl[C_REG_WRITE]  = 1'b1;
                o_ctrl[C_MEM_TO_REG] = 1'b1;
                o_wreg               = i_instr[8:6];
            end
            OP_SW: begin
                o_ctrl[C_ALU_SRC]   = 1'b1;
                o_ctrl[C_MEM_WRITE] = 1'b1;
                o_uses_rt           = 1'b1;
            end
            OP_BEQ: begin
                o_alu_op         = ALU_SUB;
                o_ctrl[C_BRANCH] = 1'b1;
                o_uses_rt        = 1'b1;
            end
            OP_J: o_ctrl[C_JUMP] = 1'b1;
            default: ;
        endcase
        if (o_wreg == 3'd0) o_ctrl[C_REG_WRITE] = 1'b0;
    end
endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage with IF/ID and ID/EX registers, WB bypass, load-use stall and EX flush
module id_stage
    import mips16_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic              stall_if,
    input  logic              ex_flush,
    output logic [REG_AW-1:0] read_reg1,
    output logic [REG_AW-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wreg,
    output logic [2:0]        ex_alu_op,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_jtarget
);
    logic              r_if_valid;
    logic [DATA_W-1:0] r_if_instr, r_if_pc;
    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_pc, r_ex_rs_data, r_ex_rt_data, r_ex_imm, r_ex_jtarget;
    logic [REG_AW-1:0] r_ex_rs, r_ex_rt, r_ex_wreg;
    alu_op_e           r_ex_alu_op;
    logic [CTRL_W-1:0] r_ex_ctrl;

    alu_op_e           w_alu_op;
    logic [CTRL_W-1:0] w_ctrl;
    logic [REG_AW-1:0] w_wreg, w_rs, w_rt;
    logic              w_uses_rt, w_hz, w_bubble;
    logic [DATA_W-1:0] w_imm, w_rs_data, w_rt_data;

    mips16_decoder #(.DATA_W(DATA_W)) u_dec (
        .i_instr   (r_if_instr),
        .o_alu_op  (w_alu_op),
        .o_ctrl    (w_ctrl),
        .o_wreg    (w_wreg),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_uses_rt (w_uses_rt),
        .o_imm     (w_imm)
    );

    assign read_reg1 = w_rs;
    assign read_reg2 = w_rt;

    assign w_rs_data = (wb_reg_write && wb_write_reg == w_rs && w_rs != '0) ? wb_write_data : read_data1;
    assign w_rt_data = (wb_reg_write && wb_write_reg == w_rt && w_rt != '0) ? wb_write_data : read_data2;

    assign w_hz = r_if_valid && r_ex_valid && r_ex_ctrl[C_MEM_READ] && (r_ex_wreg != '0)
               && (r_ex_wreg == w_rs || (r_ex_wreg == w_rt && w_uses_rt));
    assign stall_if = w_hz && !ex_flush;
    assign w_bubble = ex_flush || w_hz || !r_if_valid;

    // IF/ID: flush kills the slot, a load-use hazard holds it, otherwise take the fetched word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else if (ex_flush) begin
            r_if_valid <= 1'b0;
        end else if (!w_hz) begin
            r_if_valid <= if_valid;
            r_if_instr <= if_instr;
            r_if_pc    <= if_pc;
        end
    end

    // ID/EX: a bubble only needs valid and ctrl cleared; data fields are harmless without them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_pc      <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
            r_ex_jtarget <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_wreg    <= '0;
            r_ex_alu_op  <= ALU_ADD;
        end else begin
            r_ex_valid   <= !w_bubble;
            r_ex_ctrl    <= w_bubble ? '0 : w_ctrl;
            r_ex_pc      <= r_if_pc;
            r_ex_rs_data <= w_rs_data;
            r_ex_rt_data <= w_rt_data;
            r_ex_imm     <= w_imm;
            r_ex_jtarget <= {r_if_pc[DATA_W-1:12], r_if_instr[11:0]};
            r_ex_rs      <= w_rs;
            r_ex_rt      <= w_rt;
            r_ex_wreg    <= w_wreg;
            r_ex_alu_op  <= w_alu_op;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_ctrl    = r_ex_ctrl;
    assign ex_pc      = r_ex_pc;
    assign ex_rs_data = r_ex_rs_data;
    assign ex_rt_data = r_ex_rt_data;
    assign ex_imm     = r_ex_imm;
    assign ex_jtarget = r_ex_jtarget;
    assign ex_rs      = r_ex_rs;
    assign ex_rt      = r_ex_rt;
    assign ex_wreg    = r_ex_wreg;
    assign ex_alu_op  = r_ex_alu_op;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenario tests for the decode stage
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr, if_pc;
    logic        stall_if, ex_flush;
    logic [2:0]  read_reg1, read_reg2;
    logic [15:0] read_data1, read_data2;
    logic        wb_reg_write;
    logic [2:0]  wb_write_reg;
    logic [15:0] wb_write_data;
    logic        ex_valid;
    logic [15:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget;
    logic [2:0]  ex_rs, ex_rt, ex_wreg, ex_alu_op;
    logic [6:0]  ex_ctrl;
    int          total = 0;
    int          bad = 0;

    // Register file stand-in: each register reads back a recognisable constant
    assign read_data1 = 16'hA000 | {13'd0, read_reg1};
    assign read_data2 = 16'hB000 | {13'd0, read_reg2};

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .stall_if(stall_if), .ex_flush(ex_flush), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_alu_op(ex_alu_op),
        .ex_ctrl(ex_ctrl), .ex_jtarget(ex_jtarget)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        ex_flush = 1'b0;
        wb_reg_write = 1'b0;
        wb_write_reg = 3'd0;
        wb_write_data = 16'h0000;
        tick();
        tick();
        rst = 1'b1;
        drive(1'b1, 16'hB280, 16'h0010);
        tick();
        drive(1'b1, 16'h0498, 16'h0012);
        tick();
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL reset_pre_stall got=%b exp=1", stall_if); end
        #2 rst = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
        total++; if (ex_ctrl !== 7'h00) begin bad++; $display("FAIL reset_ex_ctrl got=%h exp=00", ex_ctrl); end
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_if); end
        tick();
        rst = 1'b1;
        drive(1'b1, 16'h0298, 16'h0020);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", ex_valid); end
        total++; if (ex_wreg !== 3'd3) begin bad++; $display("FAIL add_wreg got=%0d exp=3", ex_wreg); end
        total++; if (ex_ctrl !== 7'h08) begin bad++; $display("FAIL add_ctrl got=%h exp=08", ex_ctrl); end
        total++; if (ex_alu_op !== 3'd0) begin bad++; $display("FAIL add_alu got=%0d exp=0", ex_alu_op); end
        total++; if (ex_rs !== 3'd1 || ex_rt !== 3'd2) begin bad++; $display("FAIL add_rsrt got=%0d,%0d exp=1,2", ex_rs, ex_rt); end
        total++; if (ex_pc !== 16'h0020) begin bad++; $display("FAIL add_pc got=%h exp=0020", ex_pc); end
        total++; if (ex_rs_data !== 16'hA001) begin bad++; $display("FAIL add_rs_data got=%h exp=a001", ex_rs_data); end
        total++; if (ex_rt_data !== 16'hB002) begin bad++; $display("FAIL add_rt_data got=%h exp=b002", ex_rt_data); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 16'h0298, 16'h0022);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        wb_reg_write = 1'b1; wb_write_reg = 3'd1; wb_write_data = 16'h1234;
        tick();
        total++; if (ex_rs_data !== 16'h1234) begin bad++; $display("FAIL byp_rs got=%h exp=1234", ex_rs_data); end
        total++; if (ex_rt_data !== 16'hB002) begin bad++; $display("FAIL byp_rs_other got=%h exp=b002", ex_rt_data); end
        wb_reg_write = 1'b0;
        drive(1'b1, 16'h0298, 16'h0024);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        wb_reg_write = 1'b1; wb_write_reg = 3'd2; wb_write_data = 16'h5678;
        tick();
        total++; if (ex_rt_data !== 16'h5678) begin bad++; $display("FAIL byp_rt got=%h exp=5678", ex_rt_data); end
        total++; if (ex_rs_data !== 16'hA001) begin bad++; $display("FAIL byp_rt_other got=%h exp=a001", ex_rs_data); end
        wb_reg_write = 1'b0;
        drive(1'b1, 16'h0098, 16'h0026);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        wb_reg_write = 1'b1; wb_write_reg = 3'd0; wb_write_data = 16'hDEAD;
        tick();
        total++; if (ex_rs_data !== 16'hA000) begin bad++; $display("FAIL byp_r0 got=%h exp=a000", ex_rs_data); end
        wb_reg_write = 1'b0; wb_write_reg = 3'd2; wb_write_data = 16'hBEEF;
        drive(1'b1, 16'h0298, 16'h0028);
        tick();
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        total++; if (ex_rt_data !== 16'hB002) begin bad++; $display("FAIL byp_nowrite got=%h exp=b002", ex_rt_data); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 16'hB280, 16'h0010);
        tick();
        drive(1'b1, 16'h0498, 16'h0012);
        tick();
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall_if); end
        total++; if (ex_ctrl !== 7'h6C || ex_wreg !== 3'd2) begin bad++; $display("FAIL lu_lw got=%h/%0d exp=6c/2", ex_ctrl, ex_wreg); end
        tick();
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL lu_stall_one got=%b exp=0", stall_if); end
        total++; if (ex_valid !== 1'b0 || ex_ctrl !== 7'h00) begin bad++; $display("FAIL lu_bubble got=%b/%h exp=0/00", ex_valid, ex_ctrl); end
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 16'h0012) begin bad++; $display("FAIL lu_issue got=%b/%h exp=1/0012", ex_valid, ex_pc); end
        total++; if (ex_ctrl !== 7'h08 || ex_wreg !== 3'd3 || ex_rs !== 3'd2) begin bad++; $display("FAIL lu_add got=%h/%0d/%0d exp=08/3/2", ex_ctrl, ex_wreg, ex_rs); end
        drive(1'b1, 16'hB280, 16'h0014);
        tick();
        drive(1'b1, 16'h4281, 16'h0016);
        tick();
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL lu_addi_rt got=%b exp=0", stall_if); end
        drive(1'b1, 16'hB200, 16'h0018);
        tick();
        drive(1'b1, 16'h0098, 16'h001A);
        tick();
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL lu_r0 got=%b exp=0", stall_if); end
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        tick();
    endtask

    task automatic test_flush_over_stall();
        drive(1'b1, 16'hB280, 16'h0040);
        tick();
        drive(1'b1, 16'h0498, 16'h0042);
        tick();
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL fl_pre_stall got=%b exp=1", stall_if); end
        ex_flush = 1'b1;
        #1;
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL fl_stall got=%b exp=0", stall_if); end
        tick();
        ex_flush = 1'b0;
        total++; if (ex_valid !== 1'b0 || ex_ctrl !== 7'h00) begin bad++; $display("FAIL fl_ex got=%b/%h exp=0/00", ex_valid, ex_ctrl); end
        drive(1'b1, 16'hF283, 16'h0044);
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_ifid_killed got=%b exp=0", ex_valid); end
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        total++; if (ex_valid !== 1'b1 || ex_ctrl !== 7'h50) begin bad++; $display("FAIL fl_next got=%b/%h exp=1/50", ex_valid, ex_ctrl); end
        total++; if (ex_pc !== 16'h0044 || ex_imm !== 16'h0003) begin bad++; $display("FAIL fl_next_f got=%h/%h exp=0044/0003", ex_pc, ex_imm); end
    endtask

    localparam logic [15:0] V_INSTR [9] = '{16'h4205, 16'h407F, 16'h3000, 16'h029D, 16'h8282,
                                            16'h2ABC, 16'h02A1, 16'h0DEC, 16'h028B};
    localparam logic [6:0]  V_CTRL  [9] = '{7'h40, 7'h48, 7'h00, 7'h00, 7'h02, 7'h01, 7'h08, 7'h08, 7'h08};
    localparam logic [2:0]  V_WREG  [9] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd5, 3'd1};
    localparam logic [15:0] V_IMM   [9] = '{16'h0005, 16'hFFFF, 16'h0000, 16'h001D, 16'h0002,
                                            16'hFFFC, 16'hFFE1, 16'hFFEC, 16'h000B};
    localparam logic [2:0]  V_ALU   [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd4, 3'd3};
    localparam logic [15:0] V_JT    [9] = '{16'h5205, 16'h507F, 16'h5000, 16'h529D, 16'h5282,
                                            16'h5ABC, 16'h52A1, 16'h5DEC, 16'h528B};

    task automatic test_back_to_back();
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) drive(1'b1, V_INSTR[i], 16'h5000);
            else drive(1'b0, 16'h0000, 16'h0000);
            tick();
            if (i > 0) begin
                total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL dec%0d_valid got=%b exp=1", i-1, ex_valid); end
                total++; if (ex_ctrl !== V_CTRL[i-1]) begin bad++; $display("FAIL dec%0d_ctrl got=%h exp=%h", i-1, ex_ctrl, V_CTRL[i-1]); end
                total++; if (ex_wreg !== V_WREG[i-1]) begin bad++; $display("FAIL dec%0d_wreg got=%0d exp=%0d", i-1, ex_wreg, V_WREG[i-1]); end
                total++; if (ex_imm !== V_IMM[i-1]) begin bad++; $display("FAIL dec%0d_imm got=%h exp=%h", i-1, ex_imm, V_IMM[i-1]); end
                total++; if (ex_alu_op !== V_ALU[i-1]) begin bad++; $display("FAIL dec%0d_alu got=%0d exp=%0d", i-1, ex_alu_op, V_ALU[i-1]); end
                total++; if (ex_jtarget !== V_JT[i-1]) begin bad++; $display("FAIL dec%0d_jt got=%h exp=%h", i-1, ex_jtarget, V_JT[i-1]); end
                total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL dec%0d_stall got=%b exp=0", i-1, stall_if); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_flush_over_stall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
